// File: rtl/control_refresco_if.sv
// rtl/control_refresco_if.sv - valid/ready handshake carrying the binary value to display
interface control_refresco_if;
  logic [3:0] bin;
  logic       bin_valid;
  logic       bin_ready;

  modport master (output bin, output bin_valid, input bin_ready);
  modport slave  (input bin, input bin_valid, output bin_ready);
endinterface

// File: rtl/control_refresco.sv
// rtl/control_refresco.sv - two-digit multiplexed 7-segment scan controller with frame-aligned value commit
module control_refresco #(
  parameter int DIV      = 10000,
  parameter int GUARD    = 100,
  parameter int BLANK_LZ = 1
) (
  input  logic                clk,
  input  logic                rst,
  control_refresco_if.slave   bus,
  output logic [3:0]          an,
  output logic [3:0]          digito,
  output logic                frame_done
);

  typedef enum logic {APAGADO, BARRIDO} state_t;

  localparam logic [15:0] LAST    = 16'(DIV - 1);
  localparam logic [15:0] GUARD_W = 16'(GUARD);

  logic [15:0] pcnt, pcnt_n;
  logic [1:0]  s, s_n;
  logic        tick, wrap;
  logic [3:0]  pend, disp, disp_n;
  logic        pend_full;
  logic        xfer, commit;
  state_t      state, state_n;
  logic [3:0]  an_n, digito_n, units;
  logic        low_value;

  assign bus.bin_ready = !pend_full;
  assign xfer          = bus.bin_valid && !pend_full;
  assign tick          = (pcnt == LAST);
  assign wrap          = tick && (s == 2'd3);
  // A value arriving exactly on the wrap cycle goes straight to disp so it
  // still appears in the very next frame instead of waiting an extra frame.
  assign commit        = wrap && (pend_full || xfer);
  assign pcnt_n        = tick ? 16'd0 : pcnt + 16'd1;
  assign s_n           = tick ? s + 2'd1 : s;
  assign disp_n        = commit ? (pend_full ? pend : bus.bin) : disp;
  assign low_value     = (disp_n < 4'd10);
  assign units         = low_value ? disp_n : 4'(disp_n - 4'd10);

  // Prescaler, slot index and end-of-frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt       <= 16'd0;
      s          <= 2'd0;
      frame_done <= 1'b0;
    end else begin
      pcnt       <= pcnt_n;
      s          <= s_n;
      frame_done <= wrap;
    end
  end

  // Pending/display buffering; disp only ever changes on a frame wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= 4'd0;
      pend_full <= 1'b0;
      disp      <= 4'd0;
    end else begin
      disp <= disp_n;
      if (xfer && !wrap) begin
        pend      <= bus.bin;
        pend_full <= 1'b1;
      end else if (commit) begin
        pend_full <= 1'b0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= APAGADO;
    end else begin
      state <= state_n;
    end
  end

  // Next state and next anode/digit, computed from next-cycle counters so the
  // registered outputs line up with pcnt/s of the same cycle
  always_comb begin
    state_n  = state;
    an_n     = 4'b1111;
    digito_n = 4'd0;
    if (commit) begin
      state_n = BARRIDO;
    end
    if (state_n == BARRIDO) begin
      case (s_n)
        2'd0: begin
          an_n     = 4'b1110;
          digito_n = units;
        end
        2'd1: begin
          if (!((BLANK_LZ != 0) && low_value)) begin
            an_n     = 4'b1101;
            digito_n = low_value ? 4'd0 : 4'd1;
          end
        end
        default: begin
          an_n     = 4'b1111;
          digito_n = 4'd0;
        end
      endcase
    end
    if (pcnt_n < GUARD_W) begin
      an_n = 4'b1111;
    end
  end

  // Registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      an     <= 4'b1111;
      digito <= 4'd0;
    end else begin
      an     <= an_n;
      digito <= digito_n;
    end
  end

endmodule

// File: tb/tb_control_refresco.sv
// tb/tb_control_refresco.sv - directed self-checking bench for control_refresco
module tb_control_refresco;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] an;
  logic [3:0] digito;
  logic       frame_done;

  always #5 clk = ~clk;

  control_refresco_if bus();

  control_refresco #(.DIV(8), .GUARD(2), .BLANK_LZ(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .an         (an),
    .digito     (digito),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [3:0] val;
    logic [3:0] d0;
    logic       show1;
    logic [3:0] d1;
  } vec_t;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input int c, input logic [3:0] d0, input logic show1, input logic [3:0] d1);
    int slot;
    int pc;
    logic [3:0] exp_an;
    logic [3:0] exp_dig;
    slot = c / 8;
    pc   = c % 8;
    exp_an  = 4'b1111;
    exp_dig = 4'd0;
    if (slot == 0) begin
      exp_an  = 4'b1110;
      exp_dig = d0;
    end else if (slot == 1 && show1) begin
      exp_an  = 4'b1101;
      exp_dig = d1;
    end
    if (pc < 2) exp_an = 4'b1111;
    check($sformatf("an c%0d", c), int'(an), int'(exp_an));
    check($sformatf("digito c%0d", c), int'(digito), int'(exp_dig));
    check($sformatf("frame_done c%0d", c), int'(frame_done), (c == 0) ? 1 : 0);
    check($sformatf("one_low c%0d", c), ($countones(~an) <= 1) ? 1 : 0, 1);
  endtask

  task automatic check_frame(input logic [3:0] d0, input logic show1, input logic [3:0] d1);
    for (int c = 0; c < 32; c++) begin
      check_cycle(c, d0, show1, d1);
      step();
      bus.bin_valid = 1'b0;
    end
  endtask

  task automatic offer(input logic [3:0] v);
    int n;
    logic got;
    n   = 0;
    got = 1'b0;
    bus.bin       = v;
    bus.bin_valid = 1'b1;
    while (!got && n < 40) begin
      got = bus.bin_ready;
      step();
      n++;
    end
    bus.bin_valid = 1'b0;
    check($sformatf("accept_cycles v%0d", v), n, 1);
  endtask

  task automatic wait_fd();
    int n;
    logic bad;
    n   = 0;
    bad = 1'b0;
    while (!frame_done && n < 40) begin
      if (bus.bin_ready) bad = 1'b1;
      step();
      n++;
    end
    check("frame_done_timeout", int'(frame_done), 1);
    check("stall_ready_low", int'(bad), 0);
    check("ready_after_commit", int'(bus.bin_ready), 1);
  endtask

  task automatic blank_run();
    for (int idx = 1; idx <= 64; idx++) begin
      step();
      check($sformatf("blank an i%0d", idx), int'(an), 15);
      check($sformatf("blank digito i%0d", idx), int'(digito), 0);
      check($sformatf("blank ready i%0d", idx), int'(bus.bin_ready), 1);
      check($sformatf("blank fd i%0d", idx), int'(frame_done), (idx % 32 == 0) ? 1 : 0);
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{val: 4'd7,  d0: 4'd7, show1: 1'b0, d1: 4'd0};
    vecs[1] = '{val: 4'd13, d0: 4'd3, show1: 1'b1, d1: 4'd1};
    vecs[2] = '{val: 4'd10, d0: 4'd0, show1: 1'b1, d1: 4'd1};
    vecs[3] = '{val: 4'd0,  d0: 4'd0, show1: 1'b0, d1: 4'd0};
    vecs[4] = '{val: 4'd9,  d0: 4'd9, show1: 1'b0, d1: 4'd0};
    vecs[5] = '{val: 4'd15, d0: 4'd5, show1: 1'b1, d1: 4'd1};

    bus.bin       = 4'd0;
    bus.bin_valid = 1'b0;
    rst           = 1'b1;
    repeat (3) step();
    check("reset an", int'(an), 15);
    check("reset digito", int'(digito), 0);
    check("reset frame_done", int'(frame_done), 0);
    check("reset ready", int'(bus.bin_ready), 1);
    rst = 1'b0;
    blank_run();

    for (int i = 0; i < 6; i++) begin
      repeat (5) step();
      offer(vecs[i].val);
      wait_fd();
      check_frame(vecs[i].d0, vecs[i].show1, vecs[i].d1);
    end

    repeat (4) step();
    check("pre_reset an", int'(an), 14);
    check("pre_reset digito", int'(digito), 5);
    rst = 1'b1;
    step();
    check("midreset an", int'(an), 15);
    check("midreset digito", int'(digito), 0);
    check("midreset ready", int'(bus.bin_ready), 1);
    check("midreset frame_done", int'(frame_done), 0);
    rst = 1'b0;
    blank_run();

    repeat (5) step();
    offer(4'd5);
    bus.bin       = 4'd12;
    bus.bin_valid = 1'b1;
    wait_fd();
    check_frame(4'd5, 1'b0, 4'd0);
    check_frame(4'd2, 1'b1, 4'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/control_refresco.md
CONTROL_REFRESCO -- requirements
Module: control_refresco

Interface
REQ-001 Parameter DIV, default 10000, means clock cycles per scan slot (10 kHz slot rate at 100 MHz); legal range 4..65535.
REQ-002 Parameter GUARD, default 100, means anode-off dead-time cycles at the start of each slot; legal range 0..DIV-2.
REQ-003 Parameter BLANK_LZ, default 1, means 1 blanks the tens slot when the displayed value is below 10.
REQ-004 Port clk  input  1  means the single system clock; all logic is on its rising edge.
REQ-005 Port rst  input  1  means reset, synchronous and active-high.
REQ-006 Port bin  input  4  means binary value (0..15) offered for display.
REQ-007 Port bin_valid  input  1  means bin is offered this cycle.
REQ-008 Port bin_ready  output  1  means the block accepts bin this cycle; transfer occurs when bin_valid and bin_ready are both high.
REQ-009 Port an  output  4  means the anode enables, active-low; an[i]=0 selects slot i.
REQ-010 Port digito  output  4  means the BCD digit for the currently enabled slot.
REQ-011 Port frame_done  output  1  means a one-cycle pulse on every wrap from slot 3 to slot 0.

Function
REQ-012 Prescaler pcnt SHALL count 0..DIV-1 and wrap; tick SHALL be asserted when pcnt==DIV-1.
REQ-013 Slot index s (2 bits) SHALL advance on tick, 3->0 wrap; frame_done SHALL be registered high for exactly the cycle after the wrap tick.
REQ-014 Buffering: a pending register (pend, pend_full) and a display register (disp) SHALL be provided; bin_ready = NOT pend_full.
REQ-015 On a transfer, bin SHALL be captured into pend and pend_full SHALL be set.
REQ-016 On a wrap tick with pend_full=1, pend SHALL be copied to disp and pend_full SHALL be cleared; disp never changes mid-frame.
REQ-017 On the commit cycle pend_full is 1, so no transfer is possible; bin_ready SHALL rise the following cycle.
REQ-018 Latency: a value accepted at any point in frame k SHALL appear starting at slot 0 of frame k+1.
REQ-019 FSM states: APAGADO, BARRIDO; APAGADO -> BARRIDO on the first commit; BARRIDO persists until reset.
REQ-020 In APAGADO, an SHALL be 4'b1111 and digito 0; prescaler and slot counter run regardless.
REQ-021 In BARRIDO, slot 0 SHALL show units (disp if disp<10, else disp-10), and slot 1 SHALL show tens (0 if disp<10, else 1).
REQ-022 Slots 2 and 3 SHALL always be blank; slot 1 SHALL be blank when BLANK_LZ=1 and disp<10.
REQ-023 Blank slot: an=4'b1111, digito=0.
REQ-024 Guard: while pcnt<GUARD, an SHALL be 4'b1111; digito SHALL already carry the new slot value.
REQ-025 an and digito SHALL be registered outputs; at most one an bit is low at any cycle.
REQ-026 Back-to-back offers while pend_full SHALL be stalled (bin_ready=0), never dropped or overwritten.

Reset
REQ-027 While rst is high on a clock edge: pcnt=0, s=0, pend_full=0, pend=0, disp=0, state=APAGADO.
REQ-028 While rst is high on a clock edge: an=4'b1111, digito=0, frame_done=0, and bin_ready=1 from the first cycle after reset.
REQ-029 Reset mid-frame SHALL discard pend and disp; display returns to blank until the next commit.

Verification (DIV=8, GUARD=2, BLANK_LZ=1)
REQ-030 Reset, no input for 64 cycles -> an stays 1111, frame_done pulses every 32 cycles, bin_ready=1.
REQ-031 Offer bin=7 mid-frame -> accepted in 1 cycle, bin_ready=0 until the wrap; next frame slot 0 shows digito=7 with an=1110 during pcnt 2..7, and slot 1 is blank.
REQ-032 Offer bin=13 -> next frame slot 0 digito=3 (an=1110), slot 1 digito=1 (an=1101), slots 2 and 3 an=1111.
REQ-033 Offer 5 then immediately 12 in the same frame -> 12 is stalled until after the commit of 5; 5 shows for one full frame, then 12.
REQ-034 Assert rst during BARRIDO showing 15 -> next cycle an=1111, digito=0, bin_ready=1, and the display stays blank until a new commit.
REQ-035 Over any run, the checker confirms at most one an bit low, and an=1111 for the first 2 cycles of every slot.
